// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive path.
// Frame-buffer entries carry SOP/EOP flags alongside each data byte.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam int          MIN_FRAME     = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } buf_entry_t;

endpackage

// File: rtl/eth_crc_gen.sv
// Byte-wise CRC-32 update, MSB-first register, data bits taken LSB first.
// Over a frame plus its FCS the register settles to CRC_RESIDUE.
module eth_crc_gen
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[31] ^ data[i])
                crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
            else
                crc_out = {crc_out[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/eth_rx_framer.sv
// RMII/MII receive framer: SFD hunt, FCS check and a circular buffer
// whose frames become visible only once committed as good.
module eth_rx_framer
    import eth_pkg::*;
#(
    parameter int pMII_WIDTH = 2,
    parameter int pMAX_FRAME = 1518,
    parameter int pBUF_DEPTH = 2048
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Crs_Dv,
    input  logic [pMII_WIDTH-1:0] Rxd,
    output logic [7:0]            Out_Data,
    output logic                  Out_Sop,
    output logic                  Out_Eop,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Crc_Err,
    output logic                  Len_Err,
    output logic                  Ovf_Err,
    output logic [15:0]           Frame_Cnt
);

    localparam int AW = $clog2(pBUF_DEPTH);
    localparam logic [1:0] LANE_LAST = 2'(8 / pMII_WIDTH - 1);

    state_t               state;
    logic [7-pMII_WIDTH:0] sr;
    logic [7:0]           byte_in;
    logic [1:0]           lane;
    logic [15:0]          byte_cnt;
    logic [2:0]           held;
    logic [7:0]           dly [5];
    logic                 first_wr;
    logic                 len_flag;
    logic [31:0]          crc;
    logic [31:0]          crc_nxt;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          cm_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          cm_rd;
    buf_entry_t           ram [pBUF_DEPTH];
    buf_entry_t           wr_entry;
    logic                 byte_stb;
    logic                 over;
    logic                 push;
    logic                 fin;
    logic                 len_ok;
    logic                 frame_ok;
    logic                 full;
    logic                 wr_en;
    logic                 rd_en;

    // sr doubles as the SFD window and the byte assembler
    assign byte_in  = {Rxd, sr};
    assign byte_stb = (state == ST_DATA) && Crs_Dv && (lane == LANE_LAST);
    assign over     = byte_stb && (byte_cnt == 16'(pMAX_FRAME));
    assign push     = byte_stb && !over && (held == 3'd5);
    assign fin      = (state == ST_DATA) && !Crs_Dv;
    assign len_ok   = byte_cnt >= 16'(MIN_FRAME);
    assign frame_ok = len_ok && (crc == CRC_RESIDUE);
    assign full     = (wr_ptr[AW] != rd_ptr[AW])
                   && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    eth_crc_gen u_crc (
        .crc_in  (crc),
        .data    (byte_in),
        .crc_out (crc_nxt)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '{sop: first_wr, eop: 1'b0, data: dly[4]};
        if (push && !full)
            wr_en = 1'b1;
        if (fin && frame_ok && !full) begin
            wr_en        = 1'b1;
            wr_entry.eop = 1'b1;
        end
    end

    always_ff @(posedge Clk)
        if (wr_en)
            ram[wr_ptr[AW-1:0]] <= wr_entry;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            lane      <= '0;
            byte_cnt  <= '0;
            held      <= '0;
            first_wr  <= 1'b0;
            len_flag  <= 1'b0;
            crc       <= CRC_INIT;
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            Crc_Err   <= 1'b0;
            Len_Err   <= 1'b0;
            Ovf_Err   <= 1'b0;
            Frame_Cnt <= '0;
            for (int i = 0; i < 5; i++)
                dly[i] <= '0;
        end else begin
            Crc_Err <= 1'b0;
            Len_Err <= 1'b0;
            Ovf_Err <= 1'b0;
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                first_wr <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (Crs_Dv) begin
                        state <= ST_PREAMBLE;
                        sr    <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (!Crs_Dv) begin
                        state <= ST_IDLE;
                    end else begin
                        sr <= byte_in[7:pMII_WIDTH];
                        if (byte_in == SFD_BYTE) begin
                            state    <= ST_DATA;
                            lane     <= '0;
                            byte_cnt <= '0;
                            held     <= '0;
                            crc      <= CRC_INIT;
                            first_wr <= 1'b1;
                            len_flag <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (fin) begin
                        state <= ST_IDLE;
                        if (frame_ok && !full) begin
                            cm_ptr    <= wr_ptr + 1'b1;
                            Frame_Cnt <= Frame_Cnt + 1'b1;
                        end else begin
                            wr_ptr <= cm_ptr;
                            if (!len_ok)
                                Len_Err <= 1'b1;
                            else if (crc != CRC_RESIDUE)
                                Crc_Err <= 1'b1;
                            else
                                Ovf_Err <= 1'b1;
                        end
                    end else begin
                        sr   <= byte_in[7:pMII_WIDTH];
                        lane <= (lane == LANE_LAST) ? 2'd0 : lane + 2'd1;
                        if (byte_stb) begin
                            crc      <= crc_nxt;
                            byte_cnt <= byte_cnt + 16'd1;
                            dly[0]   <= byte_in;
                            for (int i = 1; i < 5; i++)
                                dly[i] <= dly[i-1];
                            if (held != 3'd5)
                                held <= held + 3'd1;
                            if (over) begin
                                len_flag <= 1'b1;
                                state    <= ST_DROP;
                            end else if (push && full) begin
                                state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!Crs_Dv) begin
                        state  <= ST_IDLE;
                        wr_ptr <= cm_ptr;
                        if (len_flag)
                            Len_Err <= 1'b1;
                        else
                            Ovf_Err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // read side trails the commit pointer by one cycle
    assign rd_en = (rd_ptr != cm_rd) && (!Out_Valid || Out_Ready);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr    <= '0;
            cm_rd     <= '0;
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
            Out_Data  <= '0;
        end else begin
            cm_rd <= cm_ptr;
            if (rd_en) begin
                {Out_Sop, Out_Eop, Out_Data} <= ram[rd_ptr[AW-1:0]];
                Out_Valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench: RMII, MII and small-buffer framer instances driven
// with hand-built frames whose FCS is computed by a reflected CRC model.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_cmp++; \
        assert ((OBS) === (EXP)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_eth_rx_framer;
    import eth_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       crs;
    int         sel;
    logic [1:0] rxd2;
    logic [3:0] rxd4;
    logic       crs_g [3];
    logic [7:0] od [3];
    logic       os [3];
    logic       oe [3];
    logic       ov [3];
    logic       ordy [3];
    logic       ce [3];
    logic       le [3];
    logic       fe [3];
    logic [15:0] fc [3];

    int n_cmp = 0;
    int n_err = 0;
    int crc_n [3] = '{0, 0, 0};
    int len_n [3] = '{0, 0, 0};
    int ovf_n [3] = '{0, 0, 0};
    int stall_bad = 0;
    logic       pv [3];
    logic       pr [3];
    logic [9:0] pd [3];

    logic [7:0] frm [$];
    logic [9:0] eq [$];
    logic [9:0] rq0 [$];
    logic [9:0] rq1 [$];
    logic [9:0] rq2 [$];

    assign crs_g[0] = crs && (sel == 0);
    assign crs_g[1] = crs && (sel == 1);
    assign crs_g[2] = crs && (sel == 2);

    eth_rx_framer #(.pMII_WIDTH(2)) u0 (
        .Clk(clk), .Rst_n(rst_n), .Crs_Dv(crs_g[0]), .Rxd(rxd2),
        .Out_Data(od[0]), .Out_Sop(os[0]), .Out_Eop(oe[0]),
        .Out_Valid(ov[0]), .Out_Ready(ordy[0]), .Crc_Err(ce[0]),
        .Len_Err(le[0]), .Ovf_Err(fe[0]), .Frame_Cnt(fc[0])
    );

    eth_rx_framer #(.pMII_WIDTH(4)) u1 (
        .Clk(clk), .Rst_n(rst_n), .Crs_Dv(crs_g[1]), .Rxd(rxd4),
        .Out_Data(od[1]), .Out_Sop(os[1]), .Out_Eop(oe[1]),
        .Out_Valid(ov[1]), .Out_Ready(ordy[1]), .Crc_Err(ce[1]),
        .Len_Err(le[1]), .Ovf_Err(fe[1]), .Frame_Cnt(fc[1])
    );

    eth_rx_framer #(.pMII_WIDTH(2), .pBUF_DEPTH(128)) u2 (
        .Clk(clk), .Rst_n(rst_n), .Crs_Dv(crs_g[2]), .Rxd(rxd2),
        .Out_Data(od[2]), .Out_Sop(os[2]), .Out_Eop(oe[2]),
        .Out_Valid(ov[2]), .Out_Ready(ordy[2]), .Crc_Err(ce[2]),
        .Len_Err(le[2]), .Ovf_Err(fe[2]), .Frame_Cnt(fc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ce[k] === 1'b1) crc_n[k]++;
            if (le[k] === 1'b1) len_n[k]++;
            if (fe[k] === 1'b1) ovf_n[k]++;
            if (pv[k] === 1'b1 && pr[k] === 1'b0 &&
                (ov[k] !== 1'b1 || {os[k], oe[k], od[k]} !== pd[k]))
                stall_bad++;
            if (ov[k] === 1'b1 && ordy[k] === 1'b1) begin
                case (k)
                    0: rq0.push_back({os[k], oe[k], od[k]});
                    1: rq1.push_back({os[k], oe[k], od[k]});
                    default: rq2.push_back({os[k], oe[k], od[k]});
                endcase
            end
            pv[k] = ov[k];
            pr[k] = ordy[k];
            pd[k] = {os[k], oe[k], od[k]};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build(input int n, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'((i * 13 + seed) & 255);
            frm.push_back(b);
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int j = 0; j < 4; j++)
            frm.push_back(c[8*j +: 8]);
    endtask

    task automatic expect_frame(input int n);
        for (int i = 0; i < n - 4; i++)
            eq.push_back({i == 0, i == n - 5, frm[i]});
    endtask

    task automatic send(input int k, input int nb);
        logic [7:0] b;
        int w;
        sel = k;
        w = (k == 1) ? 4 : 2;
        for (int i = 0; i < 8 + nb; i++) begin
            b = (i < 7) ? PREAMBLE_BYTE : (i == 7) ? SFD_BYTE : frm[i-8];
            for (int l = 0; l < 8 / w; l++) begin
                @(posedge clk);
                #1;
                crs  = 1'b1;
                rxd2 = b[2*l +: 2];
                if (w == 4) rxd4 = b[4*l +: 4];
            end
        end
    endtask

    task automatic tail(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            crs  = 1'b1;
            rxd2 = 2'b10;
        end
    endtask

    task automatic stop();
        @(posedge clk);
        #1;
        crs = 1'b0;
    endtask

    task automatic check_out(input int k, input string tag);
        logic [9:0] got [$];
        int bad;
        string t;
        case (k)
            0: got = rq0;
            1: got = rq1;
            default: got = rq2;
        endcase
        t = {tag, " len"};
        `CHK(t, got.size(), eq.size())
        bad = 0;
        for (int i = 0; i < got.size() && i < eq.size(); i++)
            if (got[i] !== eq[i]) bad++;
        t = {tag, " bytes"};
        `CHK(t, bad, 0)
        case (k)
            0: rq0.delete();
            1: rq1.delete();
            default: rq2.delete();
        endcase
        eq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        crs   = 1'b0;
        sel   = 0;
        rxd2  = '0;
        rxd4  = '0;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        #12;
        `CHK("rst valid", ov[0], 1'b0)
        `CHK("rst sop", os[0], 1'b0)
        `CHK("rst eop", oe[0], 1'b0)
        `CHK("rst data", od[0], 8'h00)
        `CHK("rst errs", {ce[0], le[0], fe[0]}, 3'b000)
        `CHK("rst cnt", fc[0], 16'd0)
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // good 64-byte frame, RMII
        build(64, 1);
        expect_frame(64);
        send(0, 64);
        stop();
        tick(100);
        check_out(0, "rmii64");
        `CHK("rmii64 cnt", fc[0], 16'd1)
        `CHK("rmii64 crc", crc_n[0], 0)

        // same frame, MII
        expect_frame(64);
        send(1, 64);
        stop();
        tick(100);
        check_out(1, "mii64");
        `CHK("mii64 cnt", fc[1], 16'd1)

        // single bit flip
        frm[20] = frm[20] ^ 8'h04;
        send(0, 64);
        stop();
        tick(40);
        check_out(0, "badfcs");
        `CHK("badfcs crc", crc_n[0], 1)
        `CHK("badfcs cnt", fc[0], 16'd1)
        `CHK("badfcs wptr", u0.wr_ptr, 12'd60)

        build(64, 2);
        expect_frame(64);
        send(0, 64);
        stop();
        tick(100);
        check_out(0, "after bad");
        `CHK("after bad cnt", fc[0], 16'd2)

        // runt with good FCS
        build(60, 9);
        send(0, 60);
        stop();
        tick(40);
        check_out(0, "runt");
        `CHK("runt len", len_n[0], 1)
        `CHK("runt crc", crc_n[0], 1)

        // oversize: held in DROP until carrier drops
        build(1519, 4);
        send(0, 1519);
        tail(8);
        `CHK("big drop", u0.state, ST_DROP)
        `CHK("big no pulse", len_n[0], 1)
        stop();
        tick(40);
        check_out(0, "big");
        `CHK("big len", len_n[0], 2)
        `CHK("big cnt", fc[0], 16'd2)

        build(1518, 5);
        expect_frame(1518);
        send(0, 1518);
        stop();
        tick(1600);
        check_out(0, "max");
        `CHK("max cnt", fc[0], 16'd3)
        `CHK("max len", len_n[0], 2)

        // overflow on the 128-entry buffer
        ordy[2] = 1'b0;
        build(100, 6);
        expect_frame(100);
        send(2, 100);
        stop();
        tick(10);
        build(100, 7);
        send(2, 100);
        stop();
        tick(20);
        `CHK("ovf pulse", ovf_n[2], 1)
        `CHK("ovf cnt", fc[2], 16'd1)
        ordy[2] = 1'b1;
        tick(200);
        check_out(2, "ovf out");

        // backpressure every other cycle
        build(64, 8);
        expect_frame(64);
        fork
            begin
                send(0, 64);
                stop();
                tick(200);
            end
            begin
                repeat (480) begin
                    @(posedge clk);
                    #1;
                    ordy[0] = ~ordy[0];
                end
            end
        join
        ordy[0] = 1'b1;
        tick(20);
        check_out(0, "stall");
        `CHK("stall stable", stall_bad, 0)
        `CHK("stall cnt", fc[0], 16'd4)

        // reset in the middle of a frame with a byte held at the output
        ordy[0] = 1'b0;
        build(64, 10);
        send(0, 64);
        stop();
        tick(10);
        `CHK("pre rst valid", ov[0], 1'b1)
        `CHK("pre rst cnt", fc[0], 16'd5)
        build(64, 11);
        send(0, 30);
        #2;
        rst_n = 1'b0;
        #1;
        `CHK("mid rst valid", ov[0], 1'b0)
        `CHK("mid rst sop", os[0], 1'b0)
        `CHK("mid rst data", od[0], 8'h00)
        `CHK("mid rst cnt", fc[0], 16'd0)
        `CHK("mid rst errs", {ce[0], le[0], fe[0]}, 3'b000)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eth_rx_framer.md
# eth_rx_framer

Parametrised Ethernet receive framer for RMII (2-bit) or MII (4-bit) PHY data: strips preamble/SFD, checks FCS by CRC-32 residue, strips FCS, enforces length limits, and stores frames in an internal circular buffer. A frame is released only after it passes all checks; a failing frame is dropped by rewinding the write pointer, so the buffer never needs a reset. Sits between the PHY pins and packet parsing logic, with a valid/ready byte stream downstream.

## Interface
- pMII_WIDTH, 2: data lanes per clock; legal values 2 (RMII) and 4 (MII).
- pMAX_FRAME, 1518: maximum frame bytes, DA through FCS inclusive.
- pBUF_DEPTH, 2048: buffer entries; power of two, ≥ pMAX_FRAME.
- Clk  in  1  single clock; PHY data sampled on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Crs_Dv  in  1  carrier sense / data valid.
- Rxd  in  pMII_WIDTH  receive data, LSB first.
- Out_Data  out  8  frame byte; FCS excluded.
- Out_Sop  out  1  first byte of frame.
- Out_Eop  out  1  last byte of frame.
- Out_Valid  out  1  output byte valid.
- Out_Ready  in  1  downstream accepts byte.
- Crc_Err  out  1  one-cycle pulse: frame dropped, bad FCS.
- Len_Err  out  1  one-cycle pulse: frame dropped, runt (<64) or oversize (>pMAX_FRAME).
- Ovf_Err  out  1  one-cycle pulse: frame dropped, buffer full.
- Frame_Cnt  out  16  count of committed frames; wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: Crs_Dv=1 → PREAMBLE; 8-bit window cleared.
- PREAMBLE: window <= {Rxd, window[7:pMII_WIDTH]} each cycle. When window == 8'hD5 → DATA with lane counter = 0. Crs_Dv=0 → IDLE, no error.
- DATA: bytes assembled LSB first; one byte every 8/pMII_WIDTH cycles. Each byte feeds the CRC (init 32'hFFFFFFFF, no final XOR) and a 5-deep delay line D0..D4.
- Once 5 bytes are held, each new byte pushes D4 into the buffer. The first write sets SOP.
- Byte count > pMAX_FRAME: Len_Err at frame end; writing stops; → DROP.
- Write needed but buffer full: overflow flag set; → DROP, with Ovf_Err at frame end.
- DATA with Crs_Dv=0 is frame end (cycle E). Any partial byte is discarded. The frame is good iff CRC residue == 32'hC704DD7B and byte count ≥ 64.
  - Good frame: D4 written with EOP=1; commit pointer <= write pointer + 1; Frame_Cnt increments.
  - Bad frame: write pointer <= commit pointer. Pulse Crc_Err, or Len_Err if the length check fails; Len_Err takes precedence.
  - In either case → IDLE.
- DROP: ignore Rxd until Crs_Dv=0, pulse the pending error, rewind, → IDLE.
- Entry format {SOP, EOP, byte}, 10 bits. Pointers are $clog2(pBUF_DEPTH)+1 bits with a wrap bit. Full when the MSBs differ and the rest are equal.
- Read side: reads only while read pointer ≠ commit pointer. RAM read is synchronous into the output register.
  - Out_* stay stable while Out_Valid & ~Out_Ready.
  - Back-to-back: with Out_Ready held high, one byte per cycle.
- Commit and read in the same cycle are legal; the read side sees the new commit pointer the next cycle.

## Timing
- Reset values: FSM IDLE, pointers 0, Out_Valid 0, Out_Sop/Out_Eop/Out_Data 0, error pulses 0, Frame_Cnt 0.
- Reset mid-frame discards the partial frame and all uncommitted bytes. Committed bytes are also lost.
- SFD decode to DATA: same edge on which the window becomes 8'hD5.
- Commit at E+1. Out_Valid for the frame's first byte no earlier than E+3, if the buffer was empty.
- Error pulses asserted at E+1 for exactly one cycle.
- Crs_Dv reassertion in the cycle after E: accepted as a new frame (IDLE→PREAMBLE at E+1).

## Structure
- Package eth_pkg:
  - constants: preamble 8'h55, SFD 8'hD5, CRC residue 32'hC704DD7B, minimum frame 64.
  - FSM state enum.
  - 10-bit buffer entry struct.
- Sub-module: the existing eth_crc_gen, used for the per-byte CRC update. Buffer RAM inferred inside this block.

## Test plan
- pMII_WIDTH=2, 64-byte frame (DA..FCS, valid FCS) after 7×0x55 + 0xD5 → 60 bytes out, Out_Sop on byte 0, Out_Eop on byte 59, Frame_Cnt=1.
- pMII_WIDTH=4, same frame sent as nibbles → identical output.
- Same frame with one data bit flipped → Crc_Err pulse, no Out_Valid, write pointer back to prior commit. A following good frame is output intact.
- 60-byte frame with valid FCS → Len_Err. A 1519-byte frame → Len_Err and DROP until Crs_Dv=0.
- pBUF_DEPTH=128, Out_Ready=0, two 100-byte frames → first committed, second Ovf_Err. Raise Out_Ready → exactly 96 bytes out.
- Out_Ready toggled every other cycle → output stays stable while stalled, no bytes lost or duplicated. Rst_n asserted mid-frame → all outputs 0 immediately.
